// File: rtl/ip_cu_tsk_sched_pkg.sv
// Shared definitions for the CU task scheduler: FSM state encoding and trigger width.
package ip_cu_tsk_sched_pkg;

  localparam int CU_TRG_W = 10;
  localparam int CU_ID_W  = 4;

  typedef enum logic [4:0] {
    SCH_IDLE = 5'b00001,
    SCH_SEL  = 5'b00010,
    SCH_WAIT = 5'b00100,
    SCH_GAP  = 5'b01000,
    SCH_DONE = 5'b10000
  } sch_state_e;

endpackage

// File: rtl/ip_cu_tsk_sched_if.sv
// Interface bundling frame-timing inputs and CU controller handshake of the task scheduler.
// slave: scheduler side; master: frame timing / CU controller side.
interface ip_cu_tsk_sched_if
  import ip_cu_tsk_sched_pkg::*;
#(
  parameter int CUTSK_NUM = 10,
  parameter int TO_SZ     = 12
);

  logic                 frm_start;
  logic [CUTSK_NUM-1:0] tsk_msk;
  logic [CUTSK_NUM-1:0] cu_tsk_end;
  logic [TO_SZ-1:0]     to_lmt;
  logic [CU_TRG_W-1:0]  cu_tsk_trg;
  logic [CU_ID_W-1:0]   tsk_id;
  logic                 sched_busy;
  logic                 sched_done;
  logic                 frm_ovf;
  logic                 tsk_to_err;

  modport slave (
    input  frm_start, tsk_msk, cu_tsk_end, to_lmt,
    output cu_tsk_trg, tsk_id, sched_busy, sched_done, frm_ovf, tsk_to_err
  );

  modport master (
    output frm_start, tsk_msk, cu_tsk_end, to_lmt,
    input  cu_tsk_trg, tsk_id, sched_busy, sched_done, frm_ovf, tsk_to_err
  );

endinterface

// File: rtl/ip_cu_tsk_penc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest pending task.
module ip_cu_tsk_penc #(
  parameter int N = 10
) (
  input  logic [N-1:0] req,
  output logic [3:0]   idx,
  output logic         vld
);

  // scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 4'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ip_cu_tsk_sched.sv
// CU task scheduler: on frm_start walks the enabled tasks in ascending order, pulsing a
// one-hot trigger per task and waiting for its end pulse, with GAP_CYC idle cycles between.
// Optional watchdog per task enabled by macro CU_TSK_TO_EN.
//
// state    | meaning
// SCH_IDLE | waiting for frm_start
// SCH_SEL  | pick lowest pending task and trigger it, or finish
// SCH_WAIT | waiting for the triggered task's end (or watchdog)
// SCH_GAP  | idle spacing before the next selection
// SCH_DONE | one-cycle sched_done
module ip_cu_tsk_sched
  import ip_cu_tsk_sched_pkg::*;
#(
  parameter int CUTSK_NUM = 10,
  parameter int GAP_CYC   = 2,
  parameter int TO_SZ     = 12
) (
  input logic                pclk,
  input logic                prst_n,
  ip_cu_tsk_sched_if.slave   bus
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  sch_state_e           state_q, state_d;
  logic [CUTSK_NUM-1:0] pend_q, pend_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [CU_ID_W-1:0]   tsk_id_q, tsk_id_d;
  logic [CU_TRG_W-1:0]  trg_q, trg_d;
  logic                 ovf_q, ovf_d;
  logic [3:0]           pe_idx;
  logic                 pe_vld;
  logic                 end_hit;
  logic                 to_hit;
  logic                 leave_wait;

  ip_cu_tsk_penc #(.N(CUTSK_NUM)) u_penc (
    .req (pend_q),
    .idx (pe_idx),
    .vld (pe_vld)
  );

  // only the end pulse of the task being waited on counts
  assign end_hit    = (state_q == SCH_WAIT) && bus.cu_tsk_end[tsk_id_q];
  assign leave_wait = end_hit || to_hit;

`ifdef CU_TSK_TO_EN
  logic [TO_SZ-1:0] wdog_q, wdog_d;
  logic             to_err_q, to_err_d;

  // expiry on the to_lmt-th WAIT cycle; a same-cycle end wins; to_lmt==0 disables
  assign to_hit   = (state_q == SCH_WAIT) && !end_hit && (bus.to_lmt != '0) &&
                    ((wdog_q + 1'b1) == bus.to_lmt);
  assign to_err_d = to_hit;

  // watchdog counts WAIT cycles and is held at zero elsewhere
  always_comb begin
    wdog_d = '0;
    if (state_q == SCH_WAIT) wdog_d = wdog_q + 1'b1;
  end

  // watchdog counter and error pulse registers
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      wdog_q   <= '0;
      to_err_q <= 1'b0;
    end else begin
      wdog_q   <= wdog_d;
      to_err_q <= to_err_d;
    end
  end

  assign bus.tsk_to_err = to_err_q;
`else
  logic unused_to_lmt;
  assign unused_to_lmt  = ^bus.to_lmt;
  assign to_hit         = 1'b0;
  assign bus.tsk_to_err = 1'b0;
`endif

  // state register
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) state_q <= SCH_IDLE;
    else         state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCH_IDLE: if (bus.frm_start) state_d = SCH_SEL;
      SCH_SEL:  state_d = pe_vld ? SCH_WAIT : SCH_DONE;
      SCH_WAIT: if (leave_wait) state_d = (GAP_CYC > 0) ? SCH_GAP : SCH_SEL;
      SCH_GAP:  if (gap_q == '0) state_d = SCH_SEL;
      SCH_DONE: state_d = SCH_IDLE;
      default:  state_d = SCH_IDLE;
    endcase
  end

  // datapath next values: pending mask, gap timer, trigger and task id
  always_comb begin
    pend_d   = pend_q;
    gap_d    = gap_q;
    tsk_id_d = tsk_id_q;
    trg_d    = '0;
    ovf_d    = bus.frm_start && (state_q != SCH_IDLE);
    unique case (state_q)
      SCH_IDLE: if (bus.frm_start) pend_d = bus.tsk_msk;
      SCH_SEL: begin
        if (pe_vld) begin
          tsk_id_d = pe_idx;
          trg_d    = CU_TRG_W'(1) << pe_idx;
        end
      end
      SCH_WAIT: begin
        if (leave_wait) begin
          pend_d[tsk_id_q] = 1'b0;
          if (GAP_CYC > 0) gap_d = GAP_W'(GAP_CYC - 1);
        end
      end
      SCH_GAP: if (gap_q != '0) gap_d = gap_q - 1'b1;
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      pend_q   <= '0;
      gap_q    <= '0;
      tsk_id_q <= '0;
      trg_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      gap_q    <= gap_d;
      tsk_id_q <= tsk_id_d;
      trg_q    <= trg_d;
      ovf_q    <= ovf_d;
    end
  end

  // status outputs decoded from the state register
  always_comb begin
    bus.sched_busy = (state_q != SCH_IDLE);
    bus.sched_done = (state_q == SCH_DONE);
  end

  assign bus.cu_tsk_trg = trg_q;
  assign bus.tsk_id     = tsk_id_q;
  assign bus.frm_ovf    = ovf_q;

endmodule

// File: tb/tb_ip_cu_tsk_sched.sv
// Self-checking bench for ip_cu_tsk_sched: event-level schedule model, per-cycle compare,
// directed scenarios with literal expectations, then randomized schedules.
module tb_ip_cu_tsk_sched;

  localparam int N   = 10;
  localparam int GAP = 2;
  localparam int TSZ = 12;
`ifdef CU_TSK_TO_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic pclk;
  logic prst_n;

  ip_cu_tsk_sched_if #(.CUTSK_NUM(N), .TO_SZ(TSZ)) bus ();

  ip_cu_tsk_sched #(.CUTSK_NUM(N), .GAP_CYC(GAP), .TO_SZ(TSZ)) u_dut (
    .pclk   (pclk),
    .prst_n (prst_n),
    .bus    (bus)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  int n_vec;
  int n_err;
  int cyc;
  bit chk_en;

  // model state
  bit         m_act, m_wait;
  int         m_start, m_next, m_trig, m_cur, m_end_at;
  logic [9:0] m_pend;
  bit         prev_frm, prev_busy, err_next;
  int         lat_fix;
  logic [9:0] never_msk;
  int         to_lmt_v;
  int         start_cyc;

  // expected outputs for the current cycle
  logic [9:0] e_trg;
  logic [3:0] e_id;
  bit         e_busy, e_done, e_ovf, e_err;

  // event log from the DUT for literal checks
  int         trg_cyc_q[$];
  logic [9:0] trg_val_q[$];
  int         done_cyc_q[$];
  int         ovf_cnt, err_cnt, busy_cnt;

  function automatic int lowest(input logic [9:0] v);
    for (int i = 0; i < 10; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr_log();
    trg_cyc_q.delete();
    trg_val_q.delete();
    done_cyc_q.delete();
    ovf_cnt = 0; err_cnt = 0; busy_cnt = 0;
  endtask

  task automatic model_reset();
    m_act = 0; m_wait = 0; m_pend = '0; m_end_at = -1;
    prev_frm = 0; prev_busy = 0; err_next = 0;
    e_trg = '0; e_id = '0; e_busy = 0; e_done = 0; e_ovf = 0; e_err = 0;
  endtask

  // expected outputs of this cycle, from earlier inputs only
  task automatic model_out();
    e_trg  = '0;
    e_done = 1'b0;
    e_ovf  = prev_frm && prev_busy;
    e_err  = err_next;
    err_next = 1'b0;
    e_busy = m_act && (cyc > m_start);
    if (m_act && !m_wait && cyc == m_next) begin
      if (m_pend == '0) begin
        e_done = 1'b1;
        m_act  = 1'b0;
      end else begin
        m_cur  = lowest(m_pend);
        e_trg  = 10'(1) << m_cur;
        e_id   = 4'(m_cur);
        m_wait = 1'b1;
        m_trig = cyc;
        if (never_msk[m_cur]) m_end_at = -1;
        else m_end_at = cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(8, 3)));
      end
    end
  endtask

  // effect of this cycle's inputs on the schedule
  task automatic model_in(input bit frm, input logic [9:0] msk, input logic [9:0] endv);
    if (m_wait) begin
      if (endv[m_cur]) begin
        m_pend[m_cur] = 1'b0; m_wait = 0; m_next = cyc + GAP + 2;
      end else if (TO_EN && to_lmt_v != 0 && cyc == m_trig + to_lmt_v - 1) begin
        m_pend[m_cur] = 1'b0; m_wait = 0; m_next = cyc + GAP + 2; err_next = 1'b1;
      end
    end
    if (frm && !e_busy) begin
      m_act = 1; m_start = cyc; m_next = cyc + 2; m_pend = msk; m_wait = 0;
    end
    prev_frm  = frm;
    prev_busy = e_busy;
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    cyc++;
    model_out();
  endtask

  task automatic drive(input bit frm, input logic [9:0] msk, input logic [9:0] endv);
    bus.frm_start  = frm;
    bus.tsk_msk    = frm ? msk : 10'($urandom);
    bus.cu_tsk_end = endv;
    bus.to_lmt     = TSZ'(to_lmt_v);
    model_in(frm, msk, endv);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_trg"},  int'(bus.cu_tsk_trg), 0);
    chk({nm, "_id"},   int'(bus.tsk_id), 0);
    chk({nm, "_busy"}, int'(bus.sched_busy), 0);
    chk({nm, "_done"}, int'(bus.sched_done), 0);
    chk({nm, "_ovf"},  int'(bus.frm_ovf), 0);
    chk({nm, "_err"},  int'(bus.tsk_to_err), 0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    prst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    model_reset();
    bus.frm_start = 1'b0; bus.cu_tsk_end = '0;
    repeat (2) @(posedge pclk);
    #1;
    prst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic run_sched(input logic [9:0] msk, input int lat, input logic [9:0] never,
                           input bit noise, input int abort_tsk);
    bit started;
    int budget;
    bit frm;
    logic [9:0] endv;
    started = 0; budget = 0; lat_fix = lat; never_msk = never;
    while ((!started || m_act) && budget < 3000) begin
      tick();
      budget++;
      frm = 0; endv = '0;
      if (!started) begin
        frm = 1; started = 1; start_cyc = cyc;
      end else if (noise && e_busy && $urandom_range(15) == 0) frm = 1;
      if (m_wait && cyc == m_end_at) endv[m_cur] = 1'b1;
      if (m_wait && m_cur == 1 && cyc == m_trig + 1) begin
        frm = 1; endv[5] = 1'b1;
      end
      if (noise && $urandom_range(7) == 0) begin
        endv = endv | 10'($urandom);
        if (m_wait) endv[m_cur] = (cyc == m_end_at);
      end
      if (abort_tsk >= 0 && m_wait && m_cur == abort_tsk && cyc == m_trig + 1) begin
        do_reset();
        return;
      end
      drive(frm, msk, endv);
    end
    if (budget >= 3000) begin
      n_vec++; n_err++;
      $display("FAIL sched_budget: schedule still busy after %0d cycles, required done", budget);
    end
    repeat (2) begin
      tick();
      drive(0, '0, '0);
    end
  endtask

  // per-cycle compare against the model, plus event logging
  always @(negedge pclk) begin
    if (chk_en) begin
      n_vec++;
      if (bus.cu_tsk_trg !== e_trg) begin
        n_err++; $display("FAIL trg c%0d: got %h expected %h", cyc, bus.cu_tsk_trg, e_trg);
      end
      if (bus.tsk_id !== e_id) begin
        n_err++; $display("FAIL tsk_id c%0d: got %0d expected %0d", cyc, bus.tsk_id, e_id);
      end
      if (bus.sched_busy !== e_busy) begin
        n_err++; $display("FAIL busy c%0d: got %b expected %b", cyc, bus.sched_busy, e_busy);
      end
      if (bus.sched_done !== e_done) begin
        n_err++; $display("FAIL done c%0d: got %b expected %b", cyc, bus.sched_done, e_done);
      end
      if (bus.frm_ovf !== e_ovf) begin
        n_err++; $display("FAIL ovf c%0d: got %b expected %b", cyc, bus.frm_ovf, e_ovf);
      end
      if (bus.tsk_to_err !== e_err) begin
        n_err++; $display("FAIL to_err c%0d: got %b expected %b", cyc, bus.tsk_to_err, e_err);
      end
      if (bus.cu_tsk_trg != '0) begin
        trg_cyc_q.push_back(cyc);
        trg_val_q.push_back(bus.cu_tsk_trg);
      end
      if (bus.sched_done) done_cyc_q.push_back(cyc);
      if (bus.frm_ovf) ovf_cnt++;
      if (bus.tsk_to_err) err_cnt++;
      if (bus.sched_busy) busy_cnt++;
    end
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; chk_en = 0;
    to_lmt_v = 0; lat_fix = 0; never_msk = '0;
    model_reset();
    clr_log();
    bus.frm_start = 0; bus.tsk_msk = '0; bus.cu_tsk_end = '0; bus.to_lmt = '0;
    prst_n = 1'b1;
    #1 prst_n = 1'b0;
    #1 chk_zero("rst0");
    repeat (2) @(posedge pclk);
    #1 prst_n = 1'b1;
    chk_en = 1'b1;

    // all tasks, fixed 5-cycle CU latency
    clr_log();
    run_sched(10'h3FF, 5, '0, 0, -1);
    chk("t1_ntrg", trg_val_q.size(), 10);
    if (trg_val_q.size() == 10) begin
      for (int i = 0; i < 10; i++) chk("t1_val", int'(trg_val_q[i]), 1 << i);
      chk("t1_first", trg_cyc_q[0] - start_cyc, 2);
      for (int i = 1; i < 10; i++) chk("t1_space", trg_cyc_q[i] - trg_cyc_q[i-1], 9);
      if (done_cyc_q.size() > 0) chk("t1_done_lat", done_cyc_q[0] - trg_cyc_q[9], 9);
    end
    chk("t1_ndone", done_cyc_q.size(), 1);

    // sparse mask
    clr_log();
    run_sched(10'h204, 4, '0, 0, -1);
    chk("t2_ntrg", trg_val_q.size(), 2);
    if (trg_val_q.size() == 2) begin
      chk("t2_val0", int'(trg_val_q[0]), 'h004);
      chk("t2_val1", int'(trg_val_q[1]), 'h200);
      chk("t2_space", trg_cyc_q[1] - trg_cyc_q[0], 8);
    end

    // empty mask
    clr_log();
    run_sched(10'h000, 4, '0, 0, -1);
    chk("t3_ntrg", trg_val_q.size(), 0);
    chk("t3_ndone", done_cyc_q.size(), 1);
    if (done_cyc_q.size() == 1) chk("t3_done_lat", done_cyc_q[0] - start_cyc, 2);
    chk("t3_busy", busy_cnt, 2);

    // re-pulsed frm_start and stray end during WAIT of task 1
    clr_log();
    run_sched(10'h00E, 6, '0, 0, -1);
    chk("t4_ovf", ovf_cnt, 1);
    chk("t4_ntrg", trg_val_q.size(), 3);
    if (trg_val_q.size() == 3) begin
      chk("t4_val0", int'(trg_val_q[0]), 'h002);
      chk("t4_val2", int'(trg_val_q[2]), 'h008);
    end

`ifdef CU_TSK_TO_EN
    // task 3 never ends: watchdog skips it
    clr_log();
    to_lmt_v = 16;
    run_sched(10'h038, 5, 10'h008, 0, -1);
    chk("t5_err", err_cnt, 1);
    chk("t5_ntrg", trg_val_q.size(), 3);
    if (trg_val_q.size() == 3) begin
      chk("t5_val1", int'(trg_val_q[1]), 'h010);
      chk("t5_space", trg_cyc_q[1] - trg_cyc_q[0], 19);
    end
    chk("t5_ndone", done_cyc_q.size(), 1);
    to_lmt_v = 0;
`endif

    // reset during WAIT, then restart from the lowest enabled task
    clr_log();
    run_sched(10'h3FF, 5, '0, 0, 2);
    clr_log();
    run_sched(10'h00C, 0, '0, 0, -1);
    chk("t6_ntrg", trg_val_q.size(), 2);
    if (trg_val_q.size() == 2) begin
      chk("t6_val0", int'(trg_val_q[0]), 'h004);
      chk("t6_first", trg_cyc_q[0] - start_cyc, 2);
    end

    // randomized schedules with noise
    for (int r = 0; r < 12; r++) begin
      logic [9:0] nv;
      nv = '0;
      to_lmt_v = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(10, 2));
      if (TO_EN && to_lmt_v != 0) nv = 10'($urandom) & 10'($urandom);
      run_sched(10'($urandom), 0, nv, 1, -1);
    end
    to_lmt_v = 0;

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
